// File: rtl/int_ctrl_if.sv
// Register bus between the host and the interrupt controller.
// The host drives strobes, address and write data; the controller returns
// registered read data.
interface int_ctrl_if;
    logic        bus_we;
    logic        bus_re;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_we, bus_re, bus_addr, bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_we, bus_re, bus_addr, bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/int_ctrl.sv
// Four-source interrupt controller for coprocessor 0.
// Sources are synchronized, optionally debounced, edge-detected into
// pending bits, and presented one at a time (lowest index first) on INT.
// Optional feature: define INTC_DEBOUNCE_EN to insert a per-source
// stable-level filter of DEBOUNCE_CYCLES cycles.
module int_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  irq_src,
    input  logic        INT_ACK,
    int_ctrl_if.slave   bus,
    output logic        INT,
    output logic [1:0]  int_id,
    output logic [15:0] DEBUG_INTINFO
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  sync1_q, sync2_q;
    logic [3:0]  level, prev_q, edge_hit;
    logic [3:0]  warm_q;
    logic [3:0]  pending_q, pending_d, pend_base;
    logic [3:0]  mask_q, mask_d, w1c, req_vec;
    logic [1:0]  int_id_q, int_id_d;
    logic        int_q, int_d;
    logic        eoi_wr;
    logic [31:0] rdata_q, rdata_d;
    logic        wdata_unused;

    // Two-flop synchronizer plus a warm-up shift register; edges are only
    // recognised once every stage holds a genuine post-reset sample, so a
    // source that is already high at release does not look like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            warm_q  <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
            warm_q  <= {warm_q[2:0], 1'b1};
        end
    end

`ifdef INTC_DEBOUNCE_EN
    logic [3:0] filt_q;
    logic [7:0] cnt_q [4];

    // Filtered level follows the synchronized level only after it has
    // differed for DEBOUNCE_CYCLES consecutive cycles; during warm-up the
    // filter is loaded directly so a held-high source is taken as the baseline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= '0;
            for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else if (!warm_q[2]) begin
            filt_q <= sync2_q;
            for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    // Previous filtered level for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_q <= '0;
        else        prev_q <= level;
    end

    assign edge_hit  = level & ~prev_q & {4{warm_q[3]}};
    assign w1c       = (bus.bus_we && bus.bus_addr == 2'd0) ? bus.bus_wdata[3:0] : '0;
    assign mask_d    = (bus.bus_we && bus.bus_addr == 2'd1) ? bus.bus_wdata[3:0] : mask_q;
    assign eoi_wr    = bus.bus_we && (bus.bus_addr == 2'd3);
    assign pend_base = (pending_q & ~w1c) | edge_hit;
    assign req_vec   = pending_q & mask_q;

    // Next state, request output, latched ID and pending update.
    always_comb begin
        state_d   = state_q;
        int_id_d  = int_id_q;
        int_d     = 1'b0;
        pending_d = pend_base;
        unique case (state_q)
            IDLE: begin
                if (req_vec != 4'b0000) begin
                    state_d = REQ;
                    int_d   = 1'b1;
                    if      (req_vec[0]) int_id_d = 2'd0;
                    else if (req_vec[1]) int_id_d = 2'd1;
                    else if (req_vec[2]) int_id_d = 2'd2;
                    else                 int_id_d = 2'd3;
                end
            end
            REQ: begin
                // Acknowledge wins over a same-cycle clear or unmask; a new
                // edge on the acknowledged source still re-arms its bit.
                if (INT_ACK) begin
                    pending_d = (pend_base & ~(4'b0001 << int_id_q)) | edge_hit;
                    state_d   = SERVICE;
                end else if (!pend_base[int_id_q] || !mask_d[int_id_q]) begin
                    state_d = IDLE;
                end else begin
                    int_d = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi_wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            int_id_q  <= '0;
            int_q     <= 1'b0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            int_id_q  <= int_id_d;
            int_q     <= int_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // Read mux; a read that coincides with a write returns zero.
    always_comb begin
        rdata_d = '0;
        if (bus.bus_re && !bus.bus_we) begin
            unique case (bus.bus_addr)
                2'd0:    rdata_d = {28'b0, pending_q};
                2'd1:    rdata_d = {28'b0, mask_q};
                2'd2:    rdata_d = {29'b0, state_q == SERVICE, int_id_q};
                default: rdata_d = '0;
            endcase
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign wdata_unused  = ^bus.bus_wdata[31:4];
    assign bus.bus_rdata = rdata_q;
    assign INT           = int_q;
    assign int_id        = int_id_q;
    assign DEBUG_INTINFO = {6'b0, state_q, mask_q, pending_q};

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural reference model.
`timescale 1ns/1ps
module tb_int_ctrl;

    localparam int unsigned DB_N = 16;
`ifdef INTC_DEBOUNCE_EN
    localparam int unsigned LAT = DB_N;
`else
    localparam int unsigned LAT = 0;
`endif
    localparam int unsigned PULSE = LAT + 3;
    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_SVC = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  irq_src = '0;
    logic        INT_ACK = 1'b0;
    logic        INT;
    logic [1:0]  int_id;
    logic [15:0] DEBUG_INTINFO;

    int_ctrl_if ibus();

    int_ctrl #(.DEBOUNCE_CYCLES(DB_N)) dut (
        .clk           (clk),
        .reset         (reset),
        .irq_src       (irq_src),
        .INT_ACK       (INT_ACK),
        .bus           (ibus),
        .INT           (INT),
        .int_id        (int_id),
        .DEBUG_INTINFO (DEBUG_INTINFO)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          k;
    logic [3:0]  irqs [0:4095];
    logic [3:0]  m_pend, m_mask, m_filt, m_filt_prev;
    logic [1:0]  m_state, m_id;
    logic        m_int;
    logic [31:0] m_rdata;

    task automatic model_reset();
        k = 0; m_pend = '0; m_mask = '0; m_filt = '0; m_filt_prev = '0;
        m_state = S_IDLE; m_id = '0; m_int = 1'b0; m_rdata = '0;
    endtask

    // Synchronized level seen just before edge kk: input sampled two edges earlier.
    function automatic logic [3:0] sync_b(input int kk);
        if (kk >= 3 && kk - 2 < 4096) return irqs[kk - 2];
        return 4'b0000;
    endfunction

    task automatic model_step();
        logic [3:0] edges, w1c, mask_n, pend_n, s_now, s_old, req, nf;
        logic [1:0] st_n, id_n;
        logic       int_n;
        k++;
        if (k < 4096) irqs[k] = irq_src;
`ifdef INTC_DEBOUNCE_EN
        edges = m_filt & ~m_filt_prev;
        nf = m_filt;
        if (k <= 3) nf = sync_b(k);
        else begin
            for (int i = 0; i < 4; i++) begin
                logic flip;
                flip = 1'b1;
                for (int j = 0; j < int'(DB_N); j++) begin
                    logic [3:0] s;
                    s = sync_b(k - j);
                    if (k - j < 4 || s[i] == m_filt[i]) flip = 1'b0;
                end
                if (flip) nf[i] = ~m_filt[i];
            end
        end
        m_filt_prev = m_filt;
        m_filt = nf;
`else
        s_now = sync_b(k);
        s_old = sync_b(k - 1);
        edges = s_now & ~s_old;
        nf = '0;
`endif
        if (k < 5) edges = '0;
        w1c    = (ibus.bus_we && ibus.bus_addr == 2'd0) ? ibus.bus_wdata[3:0] : 4'b0000;
        mask_n = (ibus.bus_we && ibus.bus_addr == 2'd1) ? ibus.bus_wdata[3:0] : m_mask;
        pend_n = (m_pend & ~w1c) | edges;
        m_rdata = 32'h0;
        if (ibus.bus_re && !ibus.bus_we) begin
            if (ibus.bus_addr == 2'd0) m_rdata = {28'h0, m_pend};
            if (ibus.bus_addr == 2'd1) m_rdata = {28'h0, m_mask};
            if (ibus.bus_addr == 2'd2) m_rdata = {29'h0, m_state == S_SVC, m_id};
        end
        st_n = m_state; id_n = m_id; int_n = 1'b0;
        req = m_pend & m_mask;
        if (m_state == S_IDLE) begin
            if (req != 0) begin
                st_n = S_REQ; int_n = 1'b1;
                for (int i = 3; i >= 0; i--) if (req[i]) id_n = 2'(i);
            end
        end else if (m_state == S_REQ) begin
            if (INT_ACK) begin
                pend_n[m_id] = edges[m_id];
                st_n = S_SVC;
            end else if (!pend_n[m_id] || !mask_n[m_id]) st_n = S_IDLE;
            else int_n = 1'b1;
        end else begin
            if (ibus.bus_we && ibus.bus_addr == 2'd3) st_n = S_IDLE;
        end
        m_pend = pend_n; m_mask = mask_n; m_state = st_n; m_id = id_n; m_int = int_n;
    endtask

    task automatic compare_all();
        check_eq("int", 32'(INT), 32'(m_int));
        check_eq("int_id", 32'(int_id), 32'(m_id));
        check_eq("rdata", ibus.bus_rdata, m_rdata);
        check_eq("debug", 32'(DEBUG_INTINFO), {16'h0, 6'h0, m_state, m_mask, m_pend});
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        compare_all();
        ibus.bus_we = 1'b0; ibus.bus_re = 1'b0; INT_ACK = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        ibus.bus_we = 1'b1; ibus.bus_addr = a; ibus.bus_wdata = d;
        cycle();
    endtask

    task automatic bus_read(input logic [1:0] a);
        ibus.bus_re = 1'b1; ibus.bus_addr = a;
        cycle();
    endtask

    task automatic wait_int(input string tag);
        int n = 0;
        while (!INT && n < 60) begin cycle(); n++; end
        check_eq({tag, "_int_seen"}, 32'(INT), 32'h1);
    endtask

    task automatic ack_eoi();
        INT_ACK = 1'b1; cycle();
        bus_write(2'd3, 32'h0);
    endtask

    task automatic settle();
        repeat (LAT + 4) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ibus.bus_we = 1'b0; ibus.bus_re = 1'b0; ibus.bus_addr = '0; ibus.bus_wdata = '0;
        model_reset();
        #1;
        check_eq("rst_int", 32'(INT), 32'h0);
        check_eq("rst_id", 32'(int_id), 32'h0);
        check_eq("rst_rdata", ibus.bus_rdata, 32'h0);
        check_eq("rst_debug", 32'(DEBUG_INTINFO), 32'h0);
        repeat (3) cycle();
        reset = 1'b1;
        repeat (8) cycle();

        // Single source, full handshake, CLAIM readback
        bus_write(2'd1, 32'hF);
        irq_src[2] = 1'b1; repeat (PULSE) cycle(); irq_src[2] = 1'b0;
        wait_int("r033");
        check_eq("r033_id", 32'(int_id), 32'h2);
        check_eq("r033_pend", 32'(DEBUG_INTINFO[3:0]), 32'h4);
        INT_ACK = 1'b1; cycle();
        check_eq("r033_int_after_ack", 32'(INT), 32'h0);
        check_eq("r033_pend_after_ack", 32'(DEBUG_INTINFO[3:0]), 32'h0);
        bus_read(2'd2);
        check_eq("r033_claim", ibus.bus_rdata, 32'h6);
        bus_write(2'd3, 32'h0);
        settle();

        // Simultaneous edges: priority, then the latched second request
        irq_src = 4'b1010; repeat (PULSE) cycle(); irq_src = 4'b0000;
        wait_int("r034a");
        check_eq("r034_first_id", 32'(int_id), 32'h1);
        ack_eoi();
        wait_int("r034b");
        check_eq("r034_second_id", 32'(int_id), 32'h3);
        ack_eoi();
        settle();

        // Masking the active source withdraws the request but keeps pending
        irq_src[2] = 1'b1; repeat (PULSE) cycle(); irq_src[2] = 1'b0;
        wait_int("r035");
        bus_write(2'd1, 32'h0);
        check_eq("r035_int", 32'(INT), 32'h0);
        check_eq("r035_state", 32'(DEBUG_INTINFO[9:8]), 32'h0);
        check_eq("r035_pend2", 32'(DEBUG_INTINFO[2]), 32'h1);
        bus_write(2'd0, 32'hF);
        bus_write(2'd1, 32'hF);
        settle();

        // New edge beats a same-cycle write-1-to-clear
        irq_src[0] = 1'b1; repeat (2 + LAT) cycle();
        bus_write(2'd0, 32'h1);
        check_eq("r036_pend0", 32'(DEBUG_INTINFO[0]), 32'h1);
        irq_src[0] = 1'b0;
        wait_int("r036");
        ack_eoi();
        settle();

        // Reset during SERVICE with pending bits, then a held-high source
        irq_src[0] = 1'b1; repeat (PULSE) cycle(); irq_src[0] = 1'b0;
        wait_int("r037");
        INT_ACK = 1'b1; cycle();
        irq_src = 4'b1010; repeat (PULSE) cycle(); irq_src = 4'b0000;
        repeat (2) cycle();
        check_eq("r037_pre_debug", 32'(DEBUG_INTINFO), 32'h02FA);
        irq_src = 4'b0101;
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("r037_int", 32'(INT), 32'h0);
        check_eq("r037_debug", 32'(DEBUG_INTINFO), 32'h0);
        check_eq("r037_rdata", ibus.bus_rdata, 32'h0);
        repeat (2) cycle();
        reset = 1'b1;
        repeat (8 + LAT) cycle();
        check_eq("r029_no_pend", 32'(DEBUG_INTINFO[3:0]), 32'h0);
        bus_write(2'd1, 32'hF);
        irq_src = 4'b0000; settle();
        irq_src = 4'b0101; repeat (PULSE) cycle(); irq_src = 4'b0000;
        wait_int("r029");
        check_eq("r029_id", 32'(int_id), 32'h0);
        ack_eoi();
        wait_int("r029b");
        ack_eoi();
        settle();

`ifdef INTC_DEBOUNCE_EN
        // Glitch shorter than the filter is rejected; a long pulse is taken
        irq_src[0] = 1'b1; repeat (10) cycle(); irq_src[0] = 1'b0;
        repeat (40) cycle();
        check_eq("r038_glitch", 32'(DEBUG_INTINFO[0]), 32'h0);
        irq_src[0] = 1'b1; repeat (20) cycle();
        check_eq("r038_long", 32'(DEBUG_INTINFO[0]), 32'h1);
        irq_src[0] = 1'b0;
        wait_int("r038");
        ack_eoi();
        settle();
`endif

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) irq_src[$urandom_range(0, 3)] ^= 1'b1;
            INT_ACK = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0: begin
                    ibus.bus_we = 1'b1; ibus.bus_addr = 2'($urandom_range(0, 1));
                    ibus.bus_wdata = $urandom;
                end
                1, 2: begin
                    ibus.bus_re = 1'b1; ibus.bus_addr = 2'($urandom_range(0, 3));
                end
                3: begin
                    ibus.bus_we = 1'b1; ibus.bus_re = 1'b1;
                    ibus.bus_addr = 2'($urandom_range(0, 3)); ibus.bus_wdata = $urandom;
                end
                4: begin
                    ibus.bus_we = 1'b1; ibus.bus_addr = 2'd3; ibus.bus_wdata = $urandom;
                end
                default: ;
            endcase
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the stable-level cycle count used by the debounce filter (range 2..255).
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 irq_src  input  4  SHALL carry raw asynchronous active-high interrupt sources; bit 0 is the highest priority.
REQ-005 INT_ACK  input  1  SHALL carry the one-cycle acknowledge pulse from the coprocessor-0 block.
REQ-006 bus_we  input  1  SHALL be the register write strobe.
REQ-007 bus_re  input  1  SHALL be the register read strobe.
REQ-008 bus_addr  input  2  SHALL select the register: 0 PENDING, 1 MASK, 2 CLAIM, 3 EOI.
REQ-009 bus_wdata  input  32  SHALL carry write data.
REQ-010 bus_rdata  output  32  SHALL return registered read data.
REQ-011 INT  output  1  SHALL be the registered interrupt request to coprocessor 0.
REQ-012 int_id  output  2  SHALL give the latched source ID of the current request or service.
REQ-013 DEBUG_INTINFO  output  16  SHALL equal {6'b0, state[1:0], mask[3:0], pending[3:0]}.

Function
REQ-014 Each irq_src bit SHALL pass a 2-flop synchronizer, then the filter of REQ-032, then a rising-edge detector (level registered vs. previous level).
REQ-015 Rising edge sampled by sync stage 1 at edge E0 SHALL set pending[i] at E2; INT SHALL be 1 after E3 when the source is unmasked and the FSM is IDLE.
REQ-016 A write to PENDING SHALL clear each pending bit whose bus_wdata bit is 1 (write-1-to-clear); on the same cycle, a new edge on that bit SHALL win (bit stays set).
REQ-017 A write to MASK SHALL load mask[3:0] = bus_wdata[3:0]; mask bit 1 enables the source; pending bits SHALL latch regardless of mask.
REQ-018 FSM states SHALL be IDLE(0), REQ(1), SERVICE(2).
REQ-019 IDLE: if (pending & mask) != 0, SHALL latch int_id = lowest set index, go to REQ, assert INT.
REQ-020 REQ: on INT_ACK SHALL clear pending[int_id], deassert INT, go to SERVICE next edge.
REQ-021 REQ without INT_ACK: if pending[int_id] or mask[int_id] becomes 0, SHALL deassert INT and return to IDLE; otherwise, int_id SHALL stay latched even if a higher-priority source becomes pending.
REQ-022 REQ with INT_ACK and a same-cycle W1C of pending[int_id]: acknowledge SHALL take effect (go to SERVICE).
REQ-023 SERVICE: INT SHALL stay 0; any write to EOI SHALL return the FSM to IDLE; no nesting.
REQ-024 INT_ACK in IDLE or SERVICE SHALL be ignored.
REQ-025 Reads SHALL have 1-cycle latency: PENDING -> {28'b0, pending}, MASK -> {28'b0, mask}, CLAIM -> {29'b0, in_service, int_id}, EOI -> 0; bus_rdata SHALL be 0 in cycles without bus_re.
REQ-026 Simultaneous bus_we and bus_re SHALL perform the write and return 0.

Reset
REQ-027 Asserting reset SHALL immediately force INT=0, int_id=0, bus_rdata=0, pending=0, mask=4'b0000, FSM=IDLE, and clear synchronizer, edge, and debounce state.
REQ-028 Reset asserted during REQ or SERVICE SHALL abandon the request; no pending bit SHALL survive.
REQ-029 After release, a source already high SHALL NOT generate a pending bit until it falls and rises again.

Configuration
REQ-030 Macro INTC_DEBOUNCE_EN SHALL select the debounce filter.
REQ-031 Without INTC_DEBOUNCE_EN: filtered level SHALL equal the synchronized level; no counters SHALL be instantiated.
REQ-032 With INTC_DEBOUNCE_EN: each filtered level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion SHALL reset that source's counter; edge-to-pending latency SHALL grow by DEBOUNCE_CYCLES.

Verification
REQ-033 MASK=4'hF, pulse irq_src[2] -> pending=4'b0100 at E2, INT=1 after E3, int_id=2; INT_ACK -> INT=0, pending=0, CLAIM read=32'h6.
REQ-034 MASK=4'hF, edges on bits 3 and 1 in the same cycle -> int_id=1; after ACK+EOI, second request int_id=3.
REQ-035 In REQ for id 2, write MASK=4'h0 -> INT=0 next edge, FSM IDLE, pending[2] still 1.
REQ-036 Same-cycle edge on bit 0 and PENDING write 32'h1 -> pending[0]=1.
REQ-037 Reset pulsed while in SERVICE with pending=4'b1010 -> INT=0, pending=0, mask=0, DEBUG_INTINFO=16'h0000.
REQ-038 With INTC_DEBOUNCE_EN and DEBOUNCE_CYCLES=16, 10-cycle glitch on irq_src[0] -> no pending; 20-cycle high -> pending[0]=1.
